// File: rtl/flght_cntrl_seq.sv
// flght_cntrl_seq: sequenced quad-rotor flight controller. A single PID datapath
// is time-shared over pitch, roll and yaw, and the three corrections are then
// mixed into four registered motor speeds.
// Optional integral term with anti-windup: define FLGHT_I_TERM_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for vld; captures angles and thrust on vld
// PTCH  | pitch PID: latch correction, shift pitch error queue
// ROLL  | roll PID: latch correction, shift roll error queue
// YAW   | yaw PID: latch correction, shift yaw error queue
// MIX   | mix corrections into motor speeds, pulse spd_vld
module flght_cntrl_seq #(
  parameter int               D_QUEUE_DEPTH = 14,
  parameter int               ERR_W         = 10,
  parameter int               DDIFF_W       = 6,
  parameter int               P_COEFF       = 5,
  parameter int               D_COEFF       = 7,
  parameter int               I_SHIFT       = 6,
  parameter int               SPD_W         = 11,
  parameter logic [SPD_W-1:0] CAL_SPEED     = 11'h1B0,
  parameter logic [12:0]      MIN_RUN_SPEED = 13'h200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic               inertial_cal,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic [8:0]         thrst,
  output logic [SPD_W-1:0]   frnt_spd,
  output logic [SPD_W-1:0]   bck_spd,
  output logic [SPD_W-1:0]   lft_spd,
  output logic [SPD_W-1:0]   rght_spd,
  output logic               spd_vld,
  output logic               busy
);

  typedef enum logic [2:0] {S_IDLE, S_PTCH, S_ROLL, S_YAW, S_MIX} state_t;

  localparam int                     CW      = 16;
  localparam logic signed [16:0]     ERR_MAX = 17'((1 << (ERR_W - 1)) - 1);
  localparam logic signed [16:0]     ERR_MIN = ~ERR_MAX;
  localparam logic signed [ERR_W:0]  DD_MAX  = (ERR_W + 1)'((1 << (DDIFF_W - 1)) - 1);
  localparam logic signed [ERR_W:0]  DD_MIN  = ~DD_MAX;
  localparam logic signed [CW-1:0]   P_C     = CW'(P_COEFF);
  localparam logic signed [CW-1:0]   D_C     = CW'(D_COEFF);
  localparam logic signed [13:0]     SPD_MAX = 14'((1 << SPD_W) - 1);

  state_t                   state_q, state_d;
  logic signed [15:0]       act_q [3], act_d [3];
  logic signed [15:0]       des_q [3], des_d [3];
  logic [8:0]               thrst_q, thrst_d;
  logic signed [ERR_W-1:0]  hist_q [3][D_QUEUE_DEPTH], hist_d [3][D_QUEUE_DEPTH];
  logic signed [12:0]       corr_q [3], corr_d [3];
  logic [SPD_W-1:0]         spd_q [4], spd_d [4];
  logic                     spd_vld_q, spd_vld_d;
  logic                     busy_q, busy_d;

  logic                     ax_act;
  logic [1:0]               ax;
  logic signed [16:0]       err_full;
  logic signed [ERR_W-1:0]  err_sat, q_old;
  logic signed [ERR_W:0]    dd_full;
  logic signed [DDIFF_W-1:0] dd_sat;
  logic signed [CW-1:0]     err_ext, dd_ext, pterm, dterm, iterm, corr_full;
  logic signed [13:0]       base, cp, cr, cy;

  // Unsigned clamp of a mixer sum onto the motor speed range.
  function automatic logic [SPD_W-1:0] usat(input logic signed [13:0] s);
    if (s < 0)             return '0;
    else if (s > SPD_MAX)  return '1;
    else                   return s[SPD_W-1:0];
  endfunction

  // Which axis the shared datapath works on this cycle.
  always_comb begin
    ax     = 2'd0;
    ax_act = 1'b0;
    case (state_q)
      S_PTCH:  begin ax = 2'd0; ax_act = 1'b1; end
      S_ROLL:  begin ax = 2'd1; ax_act = 1'b1; end
      S_YAW:   begin ax = 2'd2; ax_act = 1'b1; end
      default: ;
    endcase
  end

  // Shared P/D datapath on the selected axis.
  always_comb begin
    err_full = 17'(act_q[ax]) - 17'(des_q[ax]);
    if (err_full > ERR_MAX)      err_sat = ERR_MAX[ERR_W-1:0];
    else if (err_full < ERR_MIN) err_sat = ERR_MIN[ERR_W-1:0];
    else                         err_sat = err_full[ERR_W-1:0];

    q_old   = hist_q[ax][D_QUEUE_DEPTH-1];
    dd_full = (ERR_W + 1)'(err_sat) - (ERR_W + 1)'(q_old);
    if (dd_full > DD_MAX)      dd_sat = DD_MAX[DDIFF_W-1:0];
    else if (dd_full < DD_MIN) dd_sat = DD_MIN[DDIFF_W-1:0];
    else                       dd_sat = dd_full[DDIFF_W-1:0];

    err_ext = CW'(err_sat);
    dd_ext  = CW'(dd_sat);
    pterm   = (err_ext * P_C) >>> 3;
    dterm   = dd_ext * D_C;
  end

`ifdef FLGHT_I_TERM_EN
  logic signed [15:0] acc_q [3], acc_d [3];
  logic signed [16:0] acc_sum;
  logic signed [15:0] acc_new;
  logic               acc_clr;

  // Saturating integrator; cleared while calibrating or with zero thrust.
  always_comb begin
    acc_clr = inertial_cal || (thrst == 9'd0);
    acc_sum = 17'(acc_q[ax]) + 17'(err_sat);
    if (acc_sum > 17'sd32767)       acc_new = 16'sh7FFF;
    else if (acc_sum < -17'sd32768) acc_new = 16'sh8000;
    else                            acc_new = acc_sum[15:0];
    iterm = acc_clr ? '0 : CW'(acc_new >>> I_SHIFT);
    acc_d = acc_q;
    if (acc_clr) begin
      for (int a = 0; a < 3; a++) acc_d[a] = '0;
    end else if (ax_act) begin
      acc_d[ax] = acc_new;
    end
  end

  // Integrator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 3; a++) acc_q[a] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign iterm = '0;
`endif

  // Sequencer next-state, queue shift, correction latch and mixer.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    des_d     = des_q;
    thrst_d   = thrst_q;
    hist_d    = hist_q;
    corr_d    = corr_q;
    spd_d     = spd_q;
    spd_vld_d = 1'b0;
    corr_full = pterm + dterm + iterm;
    base      = $signed({1'b0, MIN_RUN_SPEED}) + $signed({5'd0, thrst_q});
    cp        = 14'(corr_q[0]);
    cr        = 14'(corr_q[1]);
    cy        = 14'(corr_q[2]);

    case (state_q)
      S_IDLE: begin
        if (vld) begin
          act_d[0] = ptch;   act_d[1] = roll;   act_d[2] = yaw;
          des_d[0] = d_ptch; des_d[1] = d_roll; des_d[2] = d_yaw;
          thrst_d  = thrst;
          state_d  = S_PTCH;
        end
      end
      S_PTCH: state_d = S_ROLL;
      S_ROLL: state_d = S_YAW;
      S_YAW:  state_d = S_MIX;
      S_MIX: begin
        spd_d[0]  = usat(base - cp - cy);
        spd_d[1]  = usat(base + cp - cy);
        spd_d[2]  = usat(base - cr + cy);
        spd_d[3]  = usat(base + cr + cy);
        spd_vld_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ax_act) begin
      for (int i = D_QUEUE_DEPTH - 1; i > 0; i--) hist_d[ax][i] = hist_q[ax][i-1];
      hist_d[ax][0] = err_sat;
      corr_d[ax]    = corr_full[12:0];
    end

    busy_d = (state_d != S_IDLE);
  end

  // All sequencer state; reset drops any partially computed update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      thrst_q   <= '0;
      spd_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        act_q[a]  <= '0;
        des_q[a]  <= '0;
        corr_q[a] <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++) hist_q[a][i] <= '0;
      end
      for (int m = 0; m < 4; m++) spd_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      des_q     <= des_d;
      thrst_q   <= thrst_d;
      hist_q    <= hist_d;
      corr_q    <= corr_d;
      spd_q     <= spd_d;
      spd_vld_q <= spd_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign frnt_spd = inertial_cal ? CAL_SPEED : spd_q[0];
  assign bck_spd  = inertial_cal ? CAL_SPEED : spd_q[1];
  assign lft_spd  = inertial_cal ? CAL_SPEED : spd_q[2];
  assign rght_spd = inertial_cal ? CAL_SPEED : spd_q[3];
  assign spd_vld  = spd_vld_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_flght_cntrl_seq.sv
// Bench for flght_cntrl_seq: a behavioural model (error history queues and
// plain integer PID/mix arithmetic) checked every cycle, plus literal values.
module tb_flght_cntrl_seq;
  logic        clk = 1'b0, rst_n = 1'b0, vld = 1'b0, inertial_cal = 1'b0;
  logic [15:0] d_ptch = '0, d_roll = '0, d_yaw = '0;
  logic [15:0] ptch = '0, roll = '0, yaw = '0;
  logic [8:0]  thrst = '0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        spd_vld, busy;

  always #5 clk = ~clk;

  flght_cntrl_seq dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .inertial_cal(inertial_cal),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .ptch(ptch), .roll(roll), .yaw(yaw), .thrst(thrst),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int hq [3][$];
  int acc [3];
  int m_cnt = 0;
  int m_spd [4];
  int pend [4];
  bit m_vld = 1'b0;
  int mp, mr, my, mbase;

  function automatic int clip(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int axis_corr(input int ax, input logic [15:0] a, input logic [15:0] d);
    int e, old, dd, c;
    e   = clip(int'($signed(a)) - int'($signed(d)), -512, 511);
    old = (hq[ax].size() == 14) ? hq[ax][0] : 0;
    dd  = clip(e - old, -32, 31);
    hq[ax].push_back(e);
    if (hq[ax].size() > 14) void'(hq[ax].pop_front());
    c = ((e * 5) >>> 3) + dd * 7;
`ifdef FLGHT_I_TERM_EN
    if (!(inertial_cal || thrst == 0)) begin
      acc[ax] = clip(acc[ax] + e, -32768, 32767);
      c += acc[ax] >>> 6;
    end
`endif
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_vld = 1'b0;
      for (int i = 0; i < 4; i++) m_spd[i] = 0;
      for (int a = 0; a < 3; a++) begin hq[a].delete(); acc[a] = 0; end
    end else begin
      m_vld = 1'b0;
      if (inertial_cal || thrst == 0) for (int a = 0; a < 3; a++) acc[a] = 0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_spd = pend;
          m_vld = 1'b1;
        end
      end else if (vld) begin
        mp = axis_corr(0, ptch, d_ptch);
        mr = axis_corr(1, roll, d_roll);
        my = axis_corr(2, yaw, d_yaw);
        mbase = 512 + int'(thrst);
        pend[0] = clip(mbase - mp - my, 0, 2047);
        pend[1] = clip(mbase + mp - my, 0, 2047);
        pend[2] = clip(mbase - mr + my, 0, 2047);
        pend[3] = clip(mbase + mr + my, 0, 2047);
        m_cnt = 4;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("cyc_spd_vld", spd_vld, int'(m_vld));
      chk("cyc_busy", busy, int'(m_cnt != 0));
      chk("cyc_frnt", frnt_spd, inertial_cal ? 32'h1B0 : m_spd[0]);
      chk("cyc_bck",  bck_spd,  inertial_cal ? 32'h1B0 : m_spd[1]);
      chk("cyc_lft",  lft_spd,  inertial_cal ? 32'h1B0 : m_spd[2]);
      chk("cyc_rght", rght_spd, inertial_cal ? 32'h1B0 : m_spd[3]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_update(output int lat, output int bcnt);
    @(negedge clk);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!spd_vld && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_angles(input logic [15:0] p, input logic [15:0] dp,
                            input logic [15:0] y, input logic [15:0] dy);
    ptch = p; d_ptch = dp; yaw = y; d_yaw = dy; roll = '0; d_roll = '0;
  endtask

  int lat, bc, cnt;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_frnt", frnt_spd, 0);
    chk("rst_rght", rght_spd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spd_vld", spd_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero error
    thrst = 9'h100;
    run_update(lat, bc);
    chk("zero_latency", lat, 4);
    chk("zero_busy_cycles", bc, 4);
    chk("zero_frnt", frnt_spd, 768);
    chk("zero_bck", bck_spd, 768);
    chk("zero_lft", lft_spd, 768);
    chk("zero_rght", rght_spd, 768);

    // pitch step and derivative queue depth
    do_reset();
    set_angles(16'h0040, 16'h0000, 16'h0000, 16'h0000);
    thrst = 9'h100;
    for (int k = 1; k <= 15; k++) begin
      run_update(lat, bc);
      chk("step_latency", lat, 4);
      if (k == 1) begin
`ifdef FLGHT_I_TERM_EN
        chk("step_frnt", frnt_spd, 510);
        chk("step_bck", bck_spd, 1026);
`else
        chk("step_frnt", frnt_spd, 511);
        chk("step_bck", bck_spd, 1025);
`endif
        chk("step_lft", lft_spd, 768);
        chk("step_rght", rght_spd, 768);
      end
`ifndef FLGHT_I_TERM_EN
      if (k == 14) chk("queue_upd14_frnt", frnt_spd, 511);
      if (k == 15) chk("queue_upd15_frnt", frnt_spd, 728);
`endif
    end

    // positive saturation
    do_reset();
    set_angles(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
    thrst = 9'h1FF;
    run_update(lat, bc);
    chk("sat_frnt", frnt_spd, 2047);
    chk("sat_bck", bck_spd, 1023);
`ifndef FLGHT_I_TERM_EN
    chk("sat_lft", lft_spd, 479);
    chk("sat_rght", rght_spd, 479);
`endif

    // negative clip
    do_reset();
    set_angles(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    thrst = 9'h000;
    run_update(lat, bc);
    chk("clip_frnt", frnt_spd, 0);

    // vld held every cycle
    do_reset();
    set_angles(16'h0040, 16'h0000, 16'h0000, 16'h0000);
    thrst = 9'h100;
    @(negedge clk);
    vld = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (spd_vld) cnt++;
    end
    vld = 1'b0;
    chk("burst_updates", cnt, 10);
    for (int k = 11; k <= 15; k++) begin
      run_update(lat, bc);
`ifndef FLGHT_I_TERM_EN
      if (k == 14) chk("burst_upd14_frnt", frnt_spd, 511);
      if (k == 15) chk("burst_upd15_frnt", frnt_spd, 728);
`endif
    end

    // calibration override
    @(negedge clk);
    inertial_cal = 1'b1;
    #1;
    chk("cal_frnt", frnt_spd, 12'h1B0);
    chk("cal_bck", bck_spd, 12'h1B0);
    chk("cal_lft", lft_spd, 12'h1B0);
    chk("cal_rght", rght_spd, 12'h1B0);
    run_update(lat, bc);
    chk("cal_upd_latency", lat, 4);
    chk("cal_upd_frnt", frnt_spd, 12'h1B0);
    @(negedge clk);
    inertial_cal = 1'b0;

    // reset in ROLL
    do_reset();
    set_angles(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    thrst = 9'h100;
    run_update(lat, bc);
    chk("pre_rst_frnt", frnt_spd, 768);
    @(negedge clk);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_frnt", frnt_spd, 0);
    chk("midrst_bck", bck_spd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_spd_vld", spd_vld, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (spd_vld) cnt++;
    end
    chk("midrst_no_pulse", cnt, 0);
    chk("midrst_frnt_hold", frnt_spd, 0);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flght_cntrl_seq.md
# flght_cntrl_seq

Parametrised, sequenced successor to the quad-rotor flight controller. It sits between the inertial interface / cmd_cfg and the ESC interfaces. On each valid inertial reading it runs one shared PID datapath over pitch, roll and yaw in turn, then mixes the three axis corrections into four registered motor speeds. An optional integral term with anti-windup is included, and a one-cycle `spd_vld` strobe marks each new speed set.

## Interface
Parameters:
- `D_QUEUE_DEPTH`, 14: per-axis error history depth used for the derivative term.
- `ERR_W`, 10: saturated error width, signed.
- `DDIFF_W`, 6: saturated derivative-difference width, signed.
- `P_COEFF`, 5: P gain numerator; `pterm = (err_sat*P_COEFF) >>> 3`.
- `D_COEFF`, 7: D gain; `dterm = ddiff_sat*D_COEFF`.
- `I_SHIFT`, 6: integral scaling; `iterm = acc >>> I_SHIFT`.
- `SPD_W`, 11: motor speed width, unsigned.
- `CAL_SPEED`, 11'h1B0: motor speed during inertial calibration.
- `MIN_RUN_SPEED`, 13'h200: base speed added to thrust.

Ports:
- `clk` in 1: system clock. Single clock domain; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `vld` in 1: new inertial reading valid.
- `inertial_cal` in 1: calibration in progress.
- `d_ptch`, `d_roll`, `d_yaw` in 16 each: desired angles, signed.
- `ptch`, `roll`, `yaw` in 16 each: actual angles, signed.
- `thrst` in 9: thrust, unsigned.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd` out `SPD_W` each: motor speeds.
- `spd_vld` out 1: one-cycle pulse when the speed registers update.
- `busy` out 1: high while the sequencer is not IDLE.

## Operation
- The FSM has five states: IDLE → PTCH → ROLL → YAW → MIX → IDLE, one cycle per state.
  - In IDLE with `vld`=1, capture all six angle inputs and `thrst` into holding registers, then go to PTCH.
  - Leave IDLE only on `vld`.
- Each axis state runs the shared datapath on that axis' captured inputs:
  - **Error:** `err = actual - desired` in 17 bits signed. Saturate to `ERR_W` signed: max 511, min -512.
  - **Derivative difference:** `ddiff = err_sat - q[D_QUEUE_DEPTH-1]`, saturated to `DDIFF_W` signed (31 / -32).
  - **Queue shift:** the axis queue shifts, with `q[0] <= err_sat`. Queues shift only in their own axis state.
  - **Latch:** the axis correction `C = pterm + dterm (+ iterm)` is stored, sign-extended to 13 bits.
- MIX state, with `base = MIN_RUN_SPEED + thrst`, P/R/Y = pitch/roll/yaw corrections:
  - `frnt = base - P - Y`
  - `bck = base + P - Y`
  - `lft = base - R + Y`
  - `rght = base + R + Y`
- Each sum is computed in 14 bits signed, then unsigned-saturated: negative → 0; above `2^SPD_W-1` → `2^SPD_W-1`.
- The result is written to the speed registers and `spd_vld` pulses.
- `inertial_cal`=1 forces all four speed outputs to `CAL_SPEED` combinationally. The underlying registers and the FSM keep running.
- `vld` asserted while `busy` is dropped: no capture and no queue shift.

## Timing
- Reset values: all speed registers 0, `spd_vld`=0, `busy`=0, FSM IDLE. All queues, correction registers and integrators are 0.
- `vld` sampled high in IDLE at edge N gives:
  - `busy`=1 for cycles N+1..N+4;
  - new speeds and `spd_vld`=1 visible after edge N+4, in the same cycle.
- Sustained throughput is one update per 5 cycles. A `vld` in the cycle the FSM returns to IDLE is accepted.
- Reset asserted mid-sequence: immediate return to reset values. A partial update is never published.
- Speed outputs hold their last value between updates.

## Configuration
- `FLGHT_I_TERM_EN` defined:
  - Each axis has a 16-bit signed accumulator. In its axis state it updates `acc <= sat16(acc + err_sat)`, clamped to ±32767/-32768 (anti-windup).
  - `iterm = acc_new >>> I_SHIFT` is added to `C`.
  - The accumulator clears to 0 whenever `inertial_cal`=1 or `thrst`==0.
- `FLGHT_I_TERM_EN` undefined: no accumulators; `iterm` ≡ 0.

## Test plan
All values below use defaults with I term disabled unless noted.
- **Zero error:** all angles 0, `thrst`=0x100, one `vld`. Required: all speeds 768 (0x300); `spd_vld` exactly 4 cycles after the `vld` edge; `busy` high for 4 cycles.
- **Pitch step:** `ptch`=0x40, others 0, `thrst`=0x100, first `vld`. Required: frnt=511, bck=1025, lft=rght=768.
  - With `FLGHT_I_TERM_EN`: frnt=510, bck=1026.
- **Derivative queue:** hold the pitch-step inputs for 15 `vld`s.
  - Updates 1–14: frnt=511.
  - Update 15: frnt=728, since ddiff=0.
- **Saturation:**
  - Stimulus: `ptch`=`yaw`=16'h8000, `d_ptch`=`d_yaw`=16'h7FFF, `thrst`=0x1FF.
  - Required: frnt=2047 (clipped), bck=1023, lft=rght=479.
  - Negative-clip check: `thrst`=0 with `ptch`=`yaw`=16'h7FFF, `d_ptch`=`d_yaw`=16'h8000 → frnt=0.
- **Handshake/cal:**
  - `vld` on every cycle: exactly one update per 5 cycles, and queues shift once per accepted `vld`.
  - `inertial_cal`=1: all outputs 0x1B0 immediately.
  - `rst_n` pulsed in ROLL: outputs 0, `spd_vld` never pulses.
